calc_mem_arbiter: RTL and testbench



---
 rtl/calc_mem_arbiter.sv | 112 +++++++++++
 tb/tb_calc_mem_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/calc_mem_arbiter.sv
// Round-robin arbiter with lock for the calculator's shared single-port SRAM; 1-cycle issue, read data back 2 cycles after handshake.
// Ready is combinational per requester; responses cannot be back-pressured and return in issue order.
package calculator_pkg;
  localparam int ADDR_W        = 8;
  localparam int MEM_WORD_SIZE = 64;
endpackage

module calc_mem_arbiter #(
  parameter int ADDR_W        = calculator_pkg::ADDR_W,
  parameter int MEM_WORD_SIZE = calculator_pkg::MEM_WORD_SIZE
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_0_valid_i,
  input  logic                     req_0_we_i,
  input  logic                     req_0_lock_i,
  input  logic [ADDR_W-1:0]        req_0_addr_i,
  input  logic [MEM_WORD_SIZE-1:0] req_0_wdata_i,
  output logic                     req_0_ready_o,
  output logic                     rsp_0_valid_o,
  output logic [MEM_WORD_SIZE-1:0] rsp_0_rdata_o,
  input  logic                     req_1_valid_i,
  input  logic                     req_1_we_i,
  input  logic                     req_1_lock_i,
  input  logic [ADDR_W-1:0]        req_1_addr_i,
  input  logic [MEM_WORD_SIZE-1:0] req_1_wdata_i,
  output logic                     req_1_ready_o,
  output logic                     rsp_1_valid_o,
  output logic [MEM_WORD_SIZE-1:0] rsp_1_rdata_o,
  output logic                     mem_read_o,
  output logic                     mem_write_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [MEM_WORD_SIZE-1:0] mem_wdata_o,
  input  logic [MEM_WORD_SIZE-1:0] mem_rdata_i
);

  typedef struct packed {
    logic                     we;
    logic                     lock;
    logic [ADDR_W-1:0]        addr;
    logic [MEM_WORD_SIZE-1:0] wdata;
  } mem_req_t;

  mem_req_t   req [2];
  mem_req_t   win_req;
  logic [1:0] req_vld;
  logic       last_q;
  logic       lock_act_q;
  logic       lock_own_q;
  logic       win;
  logic       win_vld;
  logic       issue;
  logic [1:0] rd_vld_q;
  logic [1:0] rd_own_q;

  assign req[0]  = {req_0_we_i, req_0_lock_i, req_0_addr_i, req_0_wdata_i};
  assign req[1]  = {req_1_we_i, req_1_lock_i, req_1_addr_i, req_1_wdata_i};
  assign req_vld = {req_1_valid_i, req_0_valid_i};

  // While locked only the owner may win, even when it has nothing pending.
  always_comb begin
    win     = 1'b0;
    win_vld = 1'b0;
    if (lock_act_q) begin
      win     = lock_own_q;
      win_vld = req_vld[lock_own_q];
    end else begin
      win_vld = |req_vld;
      win     = (&req_vld) ? ~last_q : req_vld[1];
    end
  end

  assign issue         = win_vld & rst_ni;
  assign req_0_ready_o = issue & ~win;
  assign req_1_ready_o = issue & win;
  assign win_req       = req[win];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q      <= 1'b1;
      lock_act_q  <= 1'b0;
      lock_own_q  <= 1'b0;
      mem_read_o  <= 1'b1;
      mem_write_o <= 1'b1;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      rd_vld_q    <= '0;
      rd_own_q    <= '0;
    end else begin
      mem_read_o  <= 1'b1;
      mem_write_o <= 1'b1;
      if (issue) begin
        last_q      <= win;
        lock_act_q  <= win_req.lock;
        lock_own_q  <= win;
        mem_addr_o  <= win_req.addr;
        mem_wdata_o <= win_req.wdata;
        mem_write_o <= ~win_req.we;
        mem_read_o  <= win_req.we;
      end
      // Stage 0 tags the SRAM access cycle, stage 1 the data-return cycle.
      rd_vld_q <= {rd_vld_q[0], issue & ~win_req.we};
      rd_own_q <= {rd_own_q[0], win};
    end
  end

  assign rsp_0_valid_o = rd_vld_q[1] & ~rd_own_q[1];
  assign rsp_1_valid_o = rd_vld_q[1] & rd_own_q[1];
  assign rsp_0_rdata_o = mem_rdata_i;
  assign rsp_1_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_calc_mem_arbiter.sv
// Directed bench for calc_mem_arbiter with a behavioural single-port SRAM.
module tb_calc_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 64;
  localparam logic [DW-1:0] D5 = 64'hDEAD_BEEF_0000_0001;
  localparam logic [DW-1:0] D6 = 64'h0000_0006_CAFE_0006;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          v0 = 0, we0 = 0, lk0 = 0;
  logic          v1 = 0, we1 = 0, lk1 = 0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [DW-1:0] wd0 = '0, wd1 = '0;
  logic          rdy0, rdy1, rv0, rv1;
  logic [DW-1:0] rd0, rd1;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [DW-1:0] sram [256];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  calc_mem_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_0_valid_i(v0), .req_0_we_i(we0), .req_0_lock_i(lk0),
    .req_0_addr_i(a0), .req_0_wdata_i(wd0), .req_0_ready_o(rdy0),
    .rsp_0_valid_o(rv0), .rsp_0_rdata_o(rd0),
    .req_1_valid_i(v1), .req_1_we_i(we1), .req_1_lock_i(lk1),
    .req_1_addr_i(a1), .req_1_wdata_i(wd1), .req_1_ready_o(rdy1),
    .rsp_1_valid_o(rv1), .rsp_1_rdata_o(rd1),
    .mem_read_o(mem_read), .mem_write_o(mem_write),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Registered-output SRAM: read data appears the cycle after the access cycle.
  always @(posedge clk_i) begin
    if (!mem_write) sram[mem_addr] <= mem_wdata;
    if (!mem_read)  mem_rdata <= sram[mem_addr];
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = '0;
    sram[5] = D5;
    sram[6] = D6;
    mem_rdata = '0;

    // Reset held with both requesters valid
    v0 = 1; v1 = 1; a0 = 8'h05; a1 = 8'h06;
    repeat (2) tick();
    check("rst_rdy0", rdy0, 0);
    check("rst_rdy1", rdy1, 0);
    check("rst_mem_read", mem_read, 1);
    check("rst_mem_write", mem_write, 1);
    check("rst_rv0", rv0, 0);
    check("rst_rv1", rv1, 0);
    check("rst_addr", mem_addr, 0);

    // Release: requester 0 has first priority; single read of 0x05
    rst_ni = 1; #1;
    check("rel_rdy0", rdy0, 1);
    check("rel_rdy1", rdy1, 0);
    tick();
    check("rd_mem_read", mem_read, 0);
    check("rd_mem_write", mem_write, 1);
    check("rd_addr", mem_addr, 8'h05);
    check("rd_rv0_early", rv0, 0);
    v0 = 0; v1 = 0;
    tick();
    check("rd_rv0", rv0, 1);
    check("rd_rdata0", rd0, D5);
    check("rd_rv1", rv1, 0);
    check("rd_idle_read", mem_read, 1);
    tick();
    check("rd_rv0_once", rv0, 0);

    // Write from requester 1, then read-after-write from requester 0
    v1 = 1; we1 = 1; a1 = 8'h20; wd1 = 64'h0000_0000_1234_5678; #1;
    check("waw_rdy1", rdy1, 1);
    tick();
    check("waw_mem_write", mem_write, 0);
    check("waw_mem_read", mem_read, 1);
    check("waw_addr", mem_addr, 8'h20);
    check("waw_wdata", mem_wdata, 64'h1234_5678);
    v1 = 0; v0 = 1; we0 = 0; a0 = 8'h20; #1;
    check("raw_rdy0", rdy0, 1);
    tick();
    check("raw_mem_read", mem_read, 0);
    check("raw_mem_write", mem_write, 1);
    v0 = 0;
    tick();
    check("raw_rv0", rv0, 1);
    check("raw_rdata0", rd0, 64'h1234_5678);
    tick();
    check("wr_no_rsp", rv1, 0);

    // Lock burst from requester 1 while requester 0 keeps asking
    v0 = 1; a0 = 8'h05;
    v1 = 1; we1 = 1; lk1 = 1; a1 = 8'h10; wd1 = 64'h10; #1;
    check("lk0_rdy1", rdy1, 1);
    check("lk0_rdy0", rdy0, 0);
    tick();
    check("lk0_addr", mem_addr, 8'h10);
    check("lk0_write", mem_write, 0);
    v1 = 0; #1;
    check("lk_idle_rdy0", rdy0, 0);
    check("lk_idle_rdy1", rdy1, 0);
    tick();
    check("lk_idle_write", mem_write, 1);
    check("lk_idle_read", mem_read, 1);
    v1 = 1; a1 = 8'h11; wd1 = 64'h11; #1;
    check("lk1_rdy0", rdy0, 0);
    check("lk1_rdy1", rdy1, 1);
    tick();
    check("lk1_addr", mem_addr, 8'h11);
    lk1 = 0; a1 = 8'h12; wd1 = 64'h12; #1;
    check("lk2_rdy0", rdy0, 0);
    check("lk2_rdy1", rdy1, 1);
    tick();
    check("lk2_addr", mem_addr, 8'h12);
    check("lk2_wdata", mem_wdata, 64'h12);
    v1 = 0; we1 = 0; #1;
    check("unlk_rdy0", rdy0, 1);
    tick();
    check("unlk_read", mem_read, 0);
    check("unlk_addr", mem_addr, 8'h05);
    v0 = 0;
    tick();
    check("unlk_rv0", rv0, 1);
    check("unlk_rdata0", rd0, D5);
    tick();

    // Reset one cycle after a read issue drops the in-flight read
    v0 = 1; a0 = 8'h06; #1;
    check("mf_rdy0", rdy0, 1);
    tick();
    check("mf_read", mem_read, 0);
    check("mf_addr", mem_addr, 8'h06);
    v0 = 1; v1 = 1; rst_ni = 0; #1;
    check("mf_read_hi", mem_read, 1);
    check("mf_write_hi", mem_write, 1);
    check("mf_addr0", mem_addr, 0);
    check("mf_wdata0", mem_wdata, 0);
    check("mf_rdy0_rst", rdy0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("mf_rv0", rv0, 0);
      check("mf_rv1", rv1, 0);
    end
    rst_ni = 1;

    // Contention: alternating grants starting at requester 0, responses routed back
    a0 = 8'h05; a1 = 8'h06; we0 = 0; we1 = 0; lk0 = 0; lk1 = 0;
    for (int i = 0; i < 7; i++) begin
      v0 = (i < 6); v1 = (i < 6); #1;
      if (i < 6) begin
        check("ct_rdy0", rdy0, (i % 2) == 0);
        check("ct_rdy1", rdy1, (i % 2) == 1);
      end
      tick();
      if (i < 6) begin
        check("ct_read", mem_read, 0);
        check("ct_addr", mem_addr, (i % 2) ? 8'h06 : 8'h05);
      end
      if (i >= 1) begin
        check("ct_rv0", rv0, ((i - 1) % 2) == 0);
        check("ct_rv1", rv1, ((i - 1) % 2) == 1);
        check("ct_rdata", ((i - 1) % 2) ? rd1 : rd0, ((i - 1) % 2) ? D6 : D5);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
